// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch requester
// and a data load/store requester. One transaction is in flight at a time. When
// both ports request together, data wins, unless the instruction port has already
// waited through STARVE_LIMIT data grants; in that case the instruction port wins.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   InstMem_Read/_Address        instruction fetch request (held until InstMem_Ready)
//   InstMem_In/_Ready            fetched word and one-cycle completion pulse
//   DataMem_Read/_Write          load request / per-byte store enables (held until Ready)
//   DataMem_Address/_Out         data word address and store data
//   DataMem_In/_Ready            load data and one-cycle completion pulse
//   Mem_Read/_Write/_Address     shared-memory strobes and word address
//   Mem_WriteData                shared-memory store data
//   Mem_ReadData/_Ready          shared-memory read data and completion
//   Grant                        {data,inst} one-hot of current owner, 0 when idle
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        InstMem_Read,
    input  logic [29:0] InstMem_Address,
    output logic [31:0] InstMem_In,
    output logic        InstMem_Ready,
    input  logic        DataMem_Read,
    input  logic [3:0]  DataMem_Write,
    input  logic [29:0] DataMem_Address,
    input  logic [31:0] DataMem_Out,
    output logic [31:0] DataMem_In,
    output logic        DataMem_Ready,
    output logic        Mem_Read,
    output logic [3:0]  Mem_Write,
    output logic [29:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    input  logic [31:0] Mem_ReadData,
    input  logic        Mem_Ready,
    output logic [1:0]  Grant
);

    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {StIdle, StIBusy, StDBusy, StIAck, StDAck} state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;

    logic inst_req, data_req, pick_inst;

    // A load with nonzero byte enables is treated as a store.
    assign inst_req  = InstMem_Read;
    assign data_req  = DataMem_Read | (|DataMem_Write);
    assign pick_inst = inst_req & (~data_req | (starve_q == StarveLimit));

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        case (state_q)
            StIdle: begin
                if (!inst_req) begin
                    starve_d = '0;
                end
                if (pick_inst) begin
                    state_d  = StIBusy;
                    starve_d = '0;
                    addr_d   = InstMem_Address;
                    we_d     = '0;
                    wdata_d  = '0;
                end else if (data_req) begin
                    state_d = StDBusy;
                    addr_d  = DataMem_Address;
                    we_d    = DataMem_Write;
                    wdata_d = DataMem_Out;
                    // Count data grants the waiting fetch has been passed over for.
                    if (inst_req && (starve_q != 4'hF)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StIBusy: begin
                if (Mem_Ready) begin
                    irdata_d = Mem_ReadData;
                    state_d  = StIAck;
                end
            end
            StDBusy: begin
                if (Mem_Ready) begin
                    // Store completion leaves the load-data register untouched.
                    if (we_q == 4'b0000) begin
                        drdata_d = Mem_ReadData;
                    end
                    state_d = StDAck;
                end
            end
            StIAck, StDAck: state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    // All outputs decode from state and latched registers only.
    assign Grant         = {(state_q == StDBusy) || (state_q == StDAck),
                            (state_q == StIBusy) || (state_q == StIAck)};
    assign Mem_Read      = (state_q == StIBusy) || ((state_q == StDBusy) && (we_q == 4'b0000));
    assign Mem_Write     = (state_q == StDBusy) ? we_q : 4'b0000;
    assign Mem_Address   = addr_q;
    assign Mem_WriteData = wdata_q;
    assign InstMem_Ready = (state_q == StIAck);
    assign DataMem_Ready = (state_q == StDAck);
    assign InstMem_In    = irdata_q;
    assign DataMem_In    = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then a
// randomized phase. A transaction-level model tracks the current transaction
// (owner, phase, latched request) and the per-cycle compare process checks the DUT
// against it.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE = 4;

    localparam int PhIdle = 0;
    localparam int PhBusy = 1;
    localparam int PhAck  = 2;
    localparam int PortI  = 1;
    localparam int PortD  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        InstMem_Read = 1'b0;
    logic [29:0] InstMem_Address = '0;
    logic [31:0] InstMem_In;
    logic        InstMem_Ready;
    logic        DataMem_Read = 1'b0;
    logic [3:0]  DataMem_Write = '0;
    logic [29:0] DataMem_Address = '0;
    logic [31:0] DataMem_Out = '0;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic        Mem_Read;
    logic [3:0]  Mem_Write;
    logic [29:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic [31:0] Mem_ReadData = '0;
    logic        Mem_Ready = 1'b0;
    logic [1:0]  Grant;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clock          (clock),
        .reset          (reset),
        .InstMem_Read   (InstMem_Read),
        .InstMem_Address(InstMem_Address),
        .InstMem_In     (InstMem_In),
        .InstMem_Ready  (InstMem_Ready),
        .DataMem_Read   (DataMem_Read),
        .DataMem_Write  (DataMem_Write),
        .DataMem_Address(DataMem_Address),
        .DataMem_Out    (DataMem_Out),
        .DataMem_In     (DataMem_In),
        .DataMem_Ready  (DataMem_Ready),
        .Mem_Read       (Mem_Read),
        .Mem_Write      (Mem_Write),
        .Mem_Address    (Mem_Address),
        .Mem_WriteData  (Mem_WriteData),
        .Mem_ReadData   (Mem_ReadData),
        .Mem_Ready      (Mem_Ready),
        .Grant          (Grant)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    bit          model_ok = 1'b0;
    int          m_phase = PhIdle;
    int          m_owner = 0;
    int          m_passed_over = 0;   // data grants taken while a fetch waited
    logic [29:0] m_addr = '0;
    logic [3:0]  m_we = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;

    always @(posedge clock) begin
        bit ireq, dreq;
        ireq = InstMem_Read;
        dreq = DataMem_Read || (DataMem_Write != 4'b0000);
        if (reset) begin
            model_ok      = 1'b1;
            m_phase       = PhIdle;
            m_owner       = 0;
            m_passed_over = 0;
            m_addr        = '0;
            m_we          = '0;
            m_wdata       = '0;
            m_irdata      = '0;
            m_drdata      = '0;
        end else if (m_phase == PhIdle) begin
            if (!ireq) m_passed_over = 0;
            if (ireq && (!dreq || m_passed_over == int'(STARVE))) begin
                m_owner       = PortI;
                m_phase       = PhBusy;
                m_passed_over = 0;
                m_addr        = InstMem_Address;
                m_we          = '0;
            end else if (dreq) begin
                m_owner = PortD;
                m_phase = PhBusy;
                m_addr  = DataMem_Address;
                m_we    = DataMem_Write;
                m_wdata = DataMem_Out;
                if (ireq) m_passed_over = (m_passed_over < 15) ? m_passed_over + 1 : 15;
            end
        end else if (m_phase == PhBusy) begin
            if (Mem_Ready) begin
                if (m_owner == PortI) m_irdata = Mem_ReadData;
                else if (m_we == 4'b0000) m_drdata = Mem_ReadData;
                m_phase = PhAck;
            end
        end else begin
            m_phase = PhIdle;
            m_owner = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        bit busy, ack, store;
        logic [1:0] eg;
        if (model_ok) begin
            busy  = (m_phase == PhBusy);
            ack   = (m_phase == PhAck);
            store = (m_we != 4'b0000);
            eg    = (m_phase == PhIdle) ? 2'b00 : ((m_owner == PortD) ? 2'b10 : 2'b01);
            chk("grant", 32'(Grant), 32'(eg));
            chk("mem_read", 32'(Mem_Read), 32'(busy && (m_owner == PortI || !store)));
            chk("mem_write", 32'(Mem_Write), 32'((busy && m_owner == PortD) ? m_we : 4'b0000));
            chk("inst_ready", 32'(InstMem_Ready), 32'(ack && m_owner == PortI));
            chk("data_ready", 32'(DataMem_Ready), 32'(ack && m_owner == PortD));
            chk("inst_in", InstMem_In, m_irdata);
            chk("data_in", DataMem_In, m_drdata);
            if (busy) chk("mem_address", 32'(Mem_Address), 32'(m_addr));
            if (busy && m_owner == PortD && store) chk("mem_wdata", Mem_WriteData, m_wdata);
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        int seq[$];
        bit i_pend, d_pend, d_rd, irdy_prev, drdy_prev;
        logic [3:0] d_we;
        int kind;

        // Reset values.
        reset = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_mem_read", 32'(Mem_Read), 32'h0);
        chk("rst_mem_write", 32'(Mem_Write), 32'h0);
        chk("rst_mem_address", 32'(Mem_Address), 32'h0);
        chk("rst_mem_wdata", Mem_WriteData, 32'h0);
        chk("rst_readies", 32'({InstMem_Ready, DataMem_Ready}), 32'h0);
        chk("rst_inst_in", InstMem_In, 32'h0);
        chk("rst_data_in", DataMem_In, 32'h0);
        reset = 1'b0;
        tick();

        // Zero-wait instruction fetch.
        InstMem_Read    = 1'b1;
        InstMem_Address = 30'h100;
        chk("i38_c1_mem_read", 32'(Mem_Read), 32'h0);
        tick();
        chk("i38_c2_mem_read", 32'(Mem_Read), 32'h1);
        chk("i38_c2_addr", 32'(Mem_Address), 32'h100);
        chk("i38_c2_grant", 32'(Grant), 32'h1);
        Mem_Ready    = 1'b1;
        Mem_ReadData = 32'h2402_0001;
        tick();
        chk("i38_c3_ready", 32'(InstMem_Ready), 32'h1);
        chk("i38_c3_inst_in", InstMem_In, 32'h2402_0001);
        chk("i38_c3_mem_read", 32'(Mem_Read), 32'h0);
        InstMem_Read = 1'b0;
        Mem_Ready    = 1'b0;
        tick();
        chk("i38_c4_ready", 32'(InstMem_Ready), 32'h0);

        // Partial store with two wait cycles.
        DataMem_Write   = 4'b0011;
        DataMem_Address = 30'h2A;
        DataMem_Out     = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("s39_mem_write", 32'(Mem_Write), 32'h3);
            chk("s39_mem_read", 32'(Mem_Read), 32'h0);
            chk("s39_addr", 32'(Mem_Address), 32'h2A);
            chk("s39_wdata", Mem_WriteData, 32'hDEAD_BEEF);
            if (k == 2) Mem_Ready = 1'b1;
            tick();
        end
        chk("s39_c5_ready", 32'(DataMem_Ready), 32'h1);
        chk("s39_c5_data_in", DataMem_In, 32'h0);
        chk("s39_c5_mem_write", 32'(Mem_Write), 32'h0);
        DataMem_Write = 4'b0000;
        Mem_Ready     = 1'b0;
        tick();

        // Read together with full byte enables is a store.
        DataMem_Read    = 1'b1;
        DataMem_Write   = 4'hF;
        DataMem_Address = 30'h3;
        tick();
        chk("s43_mem_read", 32'(Mem_Read), 32'h0);
        chk("s43_mem_write", 32'(Mem_Write), 32'hF);
        Mem_Ready    = 1'b1;
        Mem_ReadData = 32'h1234_5678;
        tick();
        chk("s43_ready", 32'(DataMem_Ready), 32'h1);
        chk("s43_data_in", DataMem_In, 32'h0);
        DataMem_Read  = 1'b0;
        DataMem_Write = 4'b0000;
        Mem_Ready     = 1'b0;
        tick();

        // Simultaneous requests: data first, then instruction.
        InstMem_Read    = 1'b1;
        InstMem_Address = 30'h40;
        DataMem_Read    = 1'b1;
        DataMem_Address = 30'h80;
        tick();
        chk("a40_grant_d", 32'(Grant), 32'h2);
        chk("a40_addr_d", 32'(Mem_Address), 32'h80);
        Mem_Ready    = 1'b1;
        Mem_ReadData = 32'hA5A5_0001;
        tick();
        chk("a40_dready", 32'({InstMem_Ready, DataMem_Ready}), 32'h1);
        chk("a40_data_in", DataMem_In, 32'hA5A5_0001);
        DataMem_Read = 1'b0;
        Mem_Ready    = 1'b0;
        tick();
        chk("a40_idle_grant", 32'(Grant), 32'h0);
        tick();
        chk("a40_grant_i", 32'(Grant), 32'h1);
        chk("a40_addr_i", 32'(Mem_Address), 32'h40);
        Mem_Ready    = 1'b1;
        Mem_ReadData = 32'h5A5A_0002;
        tick();
        chk("a40_iready", 32'({InstMem_Ready, DataMem_Ready}), 32'h2);
        chk("a40_inst_in", InstMem_In, 32'h5A5A_0002);
        InstMem_Read = 1'b0;
        Mem_Ready    = 1'b0;
        tick();

        // Starvation limit: four data grants, then the fetch, twice over.
        InstMem_Read = 1'b1;
        DataMem_Read = 1'b1;
        Mem_Ready    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (DataMem_Ready) seq.push_back(PortD);
            if (InstMem_Ready) seq.push_back(PortI);
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve_order[%0d]", i), 32'((i < seq.size()) ? seq[i] : 0),
                32'((i % 5 == 4) ? PortI : PortD));
        end
        InstMem_Read = 1'b0;
        DataMem_Read = 1'b0;
        repeat (3) tick();
        Mem_Ready = 1'b0;
        tick();
        chk("model_idle_after_starve", 32'(m_phase), 32'(PhIdle));

        // Reset during D_BUSY with Mem_Ready arriving afterwards.
        DataMem_Read    = 1'b1;
        DataMem_Address = 30'h55;
        tick();
        chk("r42_grant_busy", 32'(Grant), 32'h2);
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        Mem_Ready    = 1'b1;
        DataMem_Read = 1'b0;
        chk("r42_grant", 32'(Grant), 32'h0);
        chk("r42_mem_read", 32'(Mem_Read), 32'h0);
        chk("r42_mem_write", 32'(Mem_Write), 32'h0);
        chk("r42_addr", 32'(Mem_Address), 32'h0);
        chk("r42_wdata", Mem_WriteData, 32'h0);
        chk("r42_readies", 32'({InstMem_Ready, DataMem_Ready}), 32'h0);
        chk("r42_inst_in", InstMem_In, 32'h0);
        chk("r42_data_in", DataMem_In, 32'h0);
        tick();
        chk("r42_late_ready", 32'(DataMem_Ready), 32'h0);
        chk("r42_late_grant", 32'(Grant), 32'h0);
        Mem_Ready = 1'b0;
        tick();

        // Randomized traffic; requesters hold until they see their Ready pulse.
        i_pend = 1'b0;
        d_pend = 1'b0;
        d_rd   = 1'b0;
        d_we   = '0;
        for (int c = 0; c < 4000; c++) begin
            irdy_prev = InstMem_Ready;
            drdy_prev = DataMem_Ready;
            tick();
            if (irdy_prev) i_pend = 1'b0;
            if (drdy_prev) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 2) == 0) i_pend = 1'b1;
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1'b1;
                kind   = $urandom_range(0, 3);
                d_rd   = (kind != 2);
                d_we   = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'b0000;
            end
            InstMem_Read    = i_pend;
            InstMem_Address = 30'($urandom);
            DataMem_Read    = d_pend && d_rd;
            DataMem_Write   = d_pend ? d_we : 4'b0000;
            DataMem_Address = 30'($urandom);
            DataMem_Out     = $urandom;
            Mem_Ready       = 1'($urandom_range(0, 1));
            Mem_ReadData    = $urandom;
            reset           = ($urandom_range(0, 79) == 0);
        end

        InstMem_Read  = 1'b0;
        DataMem_Read  = 1'b0;
        DataMem_Write = 4'b0000;
        reset         = 1'b0;
        Mem_Ready     = 1'b1;
        repeat (4) tick();
        Mem_Ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, max consecutive data grants while an instruction request waits; legal range 1..15.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 InstMem_Read  input  1  instruction fetch request, held high until InstMem_Ready.
REQ-005 InstMem_Address  input  30  instruction word address.
REQ-006 InstMem_In  output  32  fetched instruction word to processor.
REQ-007 InstMem_Ready  output  1  one-cycle completion pulse for instruction port.
REQ-008 DataMem_Read  input  1  data load request, held until DataMem_Ready.
REQ-009 DataMem_Write  input  4  per-byte store enables, held until DataMem_Ready.
REQ-010 DataMem_Address  input  30  data word address.
REQ-011 DataMem_Out  input  32  store data from processor.
REQ-012 DataMem_In  output  32  load data to processor.
REQ-013 DataMem_Ready  output  1  one-cycle completion pulse for data port.
REQ-014 Mem_Read  output  1  shared-memory read strobe.
REQ-015 Mem_Write  output  4  shared-memory byte write enables.
REQ-016 Mem_Address  output  30  shared-memory word address.
REQ-017 Mem_WriteData  output  32  shared-memory write data.
REQ-018 Mem_ReadData  input  32  shared-memory read data, valid when Mem_Ready high.
REQ-019 Mem_Ready  input  1  shared-memory completion, one or more cycles after strobe.
REQ-020 Grant  output  2  {data,inst} one-hot of owner in BUSY/ACK states, 2'b00 in IDLE.

Function
REQ-021 States: IDLE, I_BUSY, D_BUSY, I_ACK, D_ACK; all outputs registered or decoded from state/latched regs only.
REQ-022 Data request = DataMem_Read | (|DataMem_Write); instruction request = InstMem_Read.
REQ-023 IDLE, no request: stay IDLE, Mem_Read=0, Mem_Write=4'b0.
REQ-024 IDLE, single request: go to owner BUSY; latch that port's address, write enables, write data at the same edge.
REQ-025 IDLE, both requests: data wins unless starve counter == STARVE_LIMIT, then instruction wins.
REQ-026 Starve counter: +1 (saturating at 15) on each data grant while instruction request pending; cleared on instruction grant or whenever InstMem_Read low in IDLE.
REQ-027 BUSY: Mem_Address/Mem_WriteData from latched values; Mem_Read=1 for instruction or data load; Mem_Write=latched enables for store, Mem_Read=0 then.
REQ-028 DataMem_Read and nonzero DataMem_Write together: treated as store.
REQ-029 BUSY with Mem_Ready=0: hold all Mem_* outputs stable.
REQ-030 BUSY with Mem_Ready=1: capture Mem_ReadData into owner's read-data register, go to owner ACK.
REQ-031 ACK: owner Ready=1 for exactly this cycle, Mem_Read=0, Mem_Write=0; next state IDLE unconditionally.
REQ-032 Latency: zero-wait memory (Mem_Ready in first BUSY cycle) gives Ready in cycle 3 counting request cycle as 1; each wait cycle adds one.
REQ-033 InstMem_In/DataMem_In hold last captured value until next capture on that port; store completion leaves DataMem_In unchanged.
REQ-034 Requester inputs changing during BUSY are ignored; a request still high in IDLE after ACK is a new request.
REQ-035 Never more than one of InstMem_Ready/DataMem_Ready high; never Mem_Read and nonzero Mem_Write together.

Reset
REQ-036 Reset high at clock edge: state IDLE, starve counter 0, Grant=0, Mem_Read=0, Mem_Write=0, Mem_Address=0, Mem_WriteData=0, both Ready=0, InstMem_In=0, DataMem_In=0.
REQ-037 Reset during BUSY aborts transaction; no Ready pulse issued; late Mem_Ready ignored in IDLE.

Verification
REQ-038 Inst read 0x100, zero-wait memory returns 0x24020001 -> Mem_Read high 1 cycle, Mem_Address=0x100, InstMem_Ready pulse in cycle 3, InstMem_In=0x24020001.
REQ-039 Store Write=4'b0011, address 0x2A, data 0xDEADBEEF, 2 wait cycles -> Mem_Write=4'b0011 held 3 cycles, Mem_Read=0, DataMem_Ready in cycle 5, DataMem_In unchanged.
REQ-040 Inst and data requests raised same cycle -> data served first (Grant=2'b10), then instruction (Grant=2'b01); Ready pulses never overlap.
REQ-041 InstMem_Read held, data requests back-to-back, STARVE_LIMIT=4 -> exactly 4 data grants then instruction grant; counter returns to 0.
REQ-042 Reset asserted in D_BUSY with Mem_Ready arriving next cycle -> no DataMem_Ready, all outputs at reset values, IDLE.
REQ-043 DataMem_Read=1 with DataMem_Write=4'b1111 -> store issued, Mem_Read=0.
